// File: rtl/ext_in_pkg.sv
// ext_in_pkg: shared debounce FSM states and counter sizing for ext_input_cond.
package ext_in_pkg;

    typedef enum logic [1:0] {LO, LO_PEND, HI, HI_PEND} deb_state_t;

    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ext_in_debounce.sv
// ext_in_debounce: one channel of synchroniser, debounce FSM and registered edge pulses.
module ext_in_debounce
    import ext_in_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    deb_state_t             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   rise_q, rise_d, fall_q, fall_d;
    logic                   s, level, pend, diff;

    assign s     = sync_q[SYNC_STAGES-1];
    assign level = (state_q == HI) || (state_q == HI_PEND);
    assign pend  = (state_q == LO_PEND) || (state_q == HI_PEND);
    assign diff  = s != level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= LO;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt holds the number of consecutive differing samples already seen in *_PEND
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (!diff) begin
            state_d = level ? HI : LO;
            cnt_d   = '0;
        end else if (DEB_CYCLES == 1 || (pend && cnt_q == CNT_MAX)) begin
            state_d = level ? LO : HI;
            cnt_d   = '0;
            rise_d  = !level;
            fall_d  = level;
        end else if (!pend) begin
            state_d = level ? HI_PEND : LO_PEND;
            cnt_d   = CW'(1);
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign level_o = level;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ext_input_cond.sv
// ext_input_cond: N_CH debounced external inputs with edge pulses and polarity-corrected LEDs.
// Define EXT_IN_TOGGLE_EN to make each LED a push-on/push-off latch driven by rise.
module ext_input_cond
    import ext_in_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 250000,
    parameter bit LED_ACTIVE_LOW = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] ext_sig,
    output logic [N_CH-1:0] sync_out,
    output logic [N_CH-1:0] led,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        ext_in_debounce #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (rst_n),
            .sig_i  (ext_sig[i]),
            .level_o(sync_out[i]),
            .rise_o (rise[i]),
            .fall_o (fall[i])
        );
    end

`ifdef EXT_IN_TOGGLE_EN
    logic [N_CH-1:0] tog_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tog_q <= '0;
        else        tog_q <= tog_q ^ rise;
    end

    assign led = LED_ACTIVE_LOW ? ~tog_q : tog_q;
`else
    assign led = LED_ACTIVE_LOW ? ~sync_out : sync_out;
`endif

endmodule

// File: tb/tb_ext_input_cond.sv
// tb_ext_input_cond: scoreboard bench; a sample-window reference model predicts every edge.
module tb_ext_input_cond;

    localparam int N   = 4;
    localparam int SS  = 2;
    localparam int DEB = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] ext_sig = '1;
    logic [N-1:0] sync_out, led, rise, fall;

    ext_input_cond #(
        .N_CH(N), .SYNC_STAGES(SS), .DEB_CYCLES(DEB), .LED_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ext_sig(ext_sig),
        .sync_out(sync_out), .led(led), .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] so;
        logic [N-1:0] ld;
        logic [N-1:0] ri;
        logic [N-1:0] fa;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference: s is the input delayed SS edges; a level flips once the last DEB samples of s all differ from it.
    logic [N-1:0] m_sh[SS];
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_lvl, m_tog;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < SS; k++) m_sh[k] = '0;
        m_hist.delete();
        m_lvl = '0;
        m_tog = '0;
    endtask

    function automatic exp_t exp_of(input logic [N-1:0] ri, input logic [N-1:0] fa);
        exp_t e;
        e.so = m_lvl;
`ifdef EXT_IN_TOGGLE_EN
        e.ld = ~m_tog;
`else
        e.ld = ~m_lvl;
`endif
        e.ri = ri;
        e.fa = fa;
        return e;
    endfunction

    task automatic step(input logic [N-1:0] v, input logic r);
        logic [N-1:0] s_old, ri, fa;
        bit all;
        @(negedge clk);
        ext_sig = v;
        rst_n   = r;
        if (!r) begin
            model_reset();
            sb.push_back(exp_of('0, '0));
            return;
        end
        s_old = m_sh[SS-1];
        for (int k = SS - 1; k > 0; k--) m_sh[k] = m_sh[k-1];
        m_sh[0] = v;
        m_hist.push_back(s_old);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        ri = '0;
        fa = '0;
        if (m_hist.size() == DEB) begin
            for (int ch = 0; ch < N; ch++) begin
                all = 1;
                foreach (m_hist[j]) if (m_hist[j][ch] == m_lvl[ch]) all = 0;
                if (all) begin
                    ri[ch] = !m_lvl[ch];
                    fa[ch] = m_lvl[ch];
                    m_lvl[ch] = ~m_lvl[ch];
                end
            end
        end
`ifdef EXT_IN_TOGGLE_EN
        m_tog ^= ri;
`endif
        sb.push_back(exp_of(ri, fa));
    endtask

    // Reset asserted between edges: the pending prediction for the next edge becomes the reset state.
    task automatic async_reset(input logic [N-1:0] v);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sync", sync_out, '0);
        chk("async_rst_rise", rise, '0);
        chk("async_rst_fall", fall, '0);
        chk("async_rst_led", led, '1);
        model_reset();
        if (sb.size() > 0) void'(sb.pop_back());
        sb.push_back(exp_of('0, '0));
        repeat (2) step(v, 1'b0);
        step(v, 1'b1);
    endtask

    task automatic measure(input logic [N-1:0] v, input int ch, input bit want_rise, input int exp_lat);
        int lat = -1;
        step(v, 1'b1);
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #2;
            if (lat < 0 && (want_rise ? rise[ch] : fall[ch])) lat = e;
            step(v, 1'b1);
        end
        vectors++;
        if (lat != exp_lat) begin
            miscompares++;
            $display("FAIL latency_ch%0d_%s: got %0d edges expected %0d", ch, want_rise ? "rise" : "fall", lat, exp_lat);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sync_out", sync_out, e.so);
                chk("led", led, e.ld);
                chk("rise", rise, e.ri);
                chk("fall", fall, e.fa);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        int h[N];
        model_reset();
        repeat (4) step('1, 1'b0);
        repeat (10) step('1, 1'b1);
        repeat (10) step('0, 1'b1);
        measure(4'h1, 0, 1'b1, SS + DEB);
        measure(4'h0, 0, 1'b0, SS + DEB);
        repeat (3) step(4'h2, 1'b1);
        repeat (8) step(4'h0, 1'b1);
        repeat (4) step(4'h2, 1'b1);
        repeat (10) step(4'h0, 1'b1);
        for (int i = 0; i < 40; i++) step(((i / 2) % 2 == 0) ? 4'h4 : 4'h0, 1'b1);
        repeat (10) step(4'h4, 1'b1);
        repeat (10) step(4'h0, 1'b1);
        measure(4'h9, 3, 1'b1, SS + DEB);
        repeat (10) step(4'h0, 1'b1);
        repeat (3) step(4'h2, 1'b1);
        async_reset(4'h2);
        repeat (10) step(4'h0, 1'b1);
        v = '0;
        for (int ch = 0; ch < N; ch++) h[ch] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int ch = 0; ch < N; ch++) begin
                if (h[ch] == 0) begin
                    v[ch] = ~v[ch];
                    h[ch] = $urandom_range(1, 9);
                end
                h[ch]--;
            end
            if ($urandom_range(0, 149) == 0) async_reset(v);
            else step(v, 1'b1);
        end
        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
